xor_checksum: RTL and testbench

Parametrised streaming XOR checksum and parity unit. Each frame of WIDTH-bit words is folded into one bitwise-XOR word with a parity bit, a beat count and an overlength flag. It sits between a valid/ready producer and consumer and generalises the single-bit two-input XOR gate to N words over time. Typical uses are link integrity checks and scrambler self-test.

---
 rtl/xor_checksum.sv | 107 ++++++++++
 tb/tb_xor_checksum.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_checksum.sv
// xor_checksum: folds each valid/ready frame of WIDTH-bit words into one XOR word,
//   a parity bit, a beat count and a force-close (overlength) flag.
// Latency: OUT_VALID rises one cycle after the closing beat is accepted.
// Backpressure: IN_READY is low while a result is pending (HOLD); OUT_READY drains it.
//
// Ports:
//   CLK, RST                       clock (rising edge), async active-high reset
//   IN_VALID/IN_READY/IN_DATA/IN_LAST   beat input stream
//   OUT_VALID/OUT_READY            frame result handshake
//   OUT_SUM, OUT_PARITY, OUT_COUNT, OUT_ERR   frame result fields
module xor_checksum #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter bit ODD     = 1'b0,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic             OUT_PARITY,
  output logic [CW-1:0]    OUT_COUNT,
  output logic             OUT_ERR
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             r_err;
  logic             w_accept;
  logic             w_close;

  assign w_accept = IN_VALID & IN_READY;
  // The beat being accepted is the MAX_LEN-th when cnt already holds MAX_LEN-1,
  // so the close decision is made on the pre-increment count.
  assign w_close  = w_accept & (IN_LAST | (r_cnt == CW'(MAX_LEN - 1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    IN_READY    = 1'b0;
    OUT_VALID   = 1'b0;
    case (r_state)
      ACC: begin
        IN_READY = 1'b1;
        if (w_close) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          w_state_nxt = ACC;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

  // Accumulator and result registers. Result fields are only written at a
  // close, so they stay put through HOLD and afterwards until the next close.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_close) begin
      r_sum   <= r_acc ^ IN_DATA;
      r_count <= r_cnt + 1'b1;
      r_err   <= ~IN_LAST;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_acc   <= r_acc ^ IN_DATA;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign OUT_SUM    = r_sum;
  assign OUT_COUNT  = r_count;
  assign OUT_ERR    = r_err;
  // Odd sense inverts the reduction so that sum-plus-parity has odd weight.
  assign OUT_PARITY = ODD ? ~^r_sum : ^r_sum;

endmodule

// File: tb/tb_xor_checksum.sv
module tb_xor_checksum;

  localparam int W  = 8;
  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);

  typedef struct packed {
    logic [W-1:0]  sum;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready0, out_valid0, out_parity0, out_err0;
  logic [W-1:0]  out_sum0;
  logic [CW-1:0] out_count0;
  logic          in_ready1, out_valid1, out_parity1, out_err1;
  logic [W-1:0]  out_sum1;
  logic [CW-1:0] out_count1;

  int vectors = 0;
  int miscompares = 0;

  exp_t         sb[$];
  logic [W-1:0] m_acc = '0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  xor_checksum #(.WIDTH(W), .MAX_LEN(ML), .ODD(1'b0)) u_even (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready0), .IN_DATA(in_data), .IN_LAST(in_last),
    .OUT_VALID(out_valid0), .OUT_READY(out_ready),
    .OUT_SUM(out_sum0), .OUT_PARITY(out_parity0), .OUT_COUNT(out_count0), .OUT_ERR(out_err0)
  );

  xor_checksum #(.WIDTH(W), .MAX_LEN(ML), .ODD(1'b1)) u_odd (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready1), .IN_DATA(in_data), .IN_LAST(in_last),
    .OUT_VALID(out_valid1), .OUT_READY(out_ready),
    .OUT_SUM(out_sum1), .OUT_PARITY(out_parity1), .OUT_COUNT(out_count1), .OUT_ERR(out_err1)
  );

  // Present one beat from a falling edge, wait (bounded) for IN_READY, let it be
  // accepted at the rising edge, update the reference model and push any result.
  task automatic drive_beat(input logic [W-1:0] d, input logic last);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    budget   = 0;
    while (!in_ready0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (!in_ready0) begin
      miscompares++;
      $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last || (m_cnt + 1 == ML)) begin
      sb.push_back('{sum: m_acc ^ d, cnt: CW'(m_cnt + 1), err: ~last});
      m_acc = '0;
      m_cnt = 0;
    end else begin
      m_acc = m_acc ^ d;
      m_cnt = m_cnt + 1;
    end
  endtask

  // Called right after the closing beat: the result must already be valid at
  // the next falling edge (one-cycle latency).
  task automatic check_result(input string name);
    exp_t e;
    @(negedge clk);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_scoreboard: no expected result queued, required 1", name);
      return;
    end
    e = sb.pop_front();
    if (out_valid0 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid: got %0b required 1", name, out_valid0);
    end
    vectors++;
    if (out_sum0 !== e.sum) begin
      miscompares++;
      $display("FAIL %s_sum: got %02h required %02h", name, out_sum0, e.sum);
    end
    vectors++;
    if (out_count0 !== e.cnt) begin
      miscompares++;
      $display("FAIL %s_count: got %0d required %0d", name, out_count0, e.cnt);
    end
    vectors++;
    if (out_err0 !== e.err) begin
      miscompares++;
      $display("FAIL %s_err: got %0b required %0b", name, out_err0, e.err);
    end
    vectors++;
    if (out_parity0 !== ^e.sum) begin
      miscompares++;
      $display("FAIL %s_parity_even: got %0b required %0b", name, out_parity0, ^e.sum);
    end
    vectors++;
    if (out_parity1 !== ~^e.sum) begin
      miscompares++;
      $display("FAIL %s_parity_odd: got %0b required %0b", name, out_parity1, ~^e.sum);
    end
    vectors++;
    if (in_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_hold_ready: got %0b required 0", name, in_ready0);
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_drain: valid=%0b ready=%0b required valid=0 ready=1",
               name, out_valid0, in_ready0);
    end
  endtask

  task automatic test_reset();
    // Beats offered during reset must not be counted.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_last  = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid0 !== 1'b0 || out_sum0 !== 8'h00 || out_count0 !== '0 ||
        out_err0 !== 1'b0 || in_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0b sum=%02h count=%0d err=%0b ready=%0b required 0 00 0 0 1",
               out_valid0, out_sum0, out_count0, out_err0, in_ready0);
    end
    vectors++;
    if (out_parity0 !== 1'b0 || out_parity1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_parity: even=%0b odd=%0b required 0 1", out_parity0, out_parity1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_normal_frame();
    drive_beat(8'h0F, 1'b0);
    drive_beat(8'hF0, 1'b0);
    drive_beat(8'h3C, 1'b1);
    check_result("normal");
    drain("normal");
  endtask

  task automatic test_single_beat();
    drive_beat(8'h01, 1'b1);
    check_result("single");
    drain("single");
  endtask

  task automatic test_overlength();
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    drive_beat(8'h04, 1'b0);
    drive_beat(8'h08, 1'b0);
    check_result("overlen");
    drain("overlen");
    drive_beat(8'h10, 1'b1);
    check_result("after_overlen");
    drain("after_overlen");
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  s;
    logic [CW-1:0] c;
    logic          er;
    drive_beat(8'h5A, 1'b1);
    check_result("bp_close");
    s  = out_sum0;
    c  = out_count0;
    er = out_err0;
    // Producer offers 0xFF while the result is pending; it must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_sum0 !== s ||
          out_count0 !== c || out_err0 !== er) begin
        miscompares++;
        $display("FAIL bp_hold_cycle%0d: valid=%0b ready=%0b sum=%02h count=%0d required 1 0 %02h %0d",
                 i, out_valid0, in_ready0, out_sum0, out_count0, s, c);
      end
    end
    in_valid = 1'b0;
    drain("bp_release");
    // OUT_READY asserted while accumulating has no effect.
    out_ready = 1'b1;
    drive_beat(8'hAA, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    drive_beat(8'h55, 1'b1);
    check_result("gap");
    drain("gap");
  endtask

  task automatic test_async_reset();
    drive_beat(8'h11, 1'b0);
    drive_beat(8'h22, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid0 !== 1'b0 || out_sum0 !== 8'h00 || out_count0 !== '0 ||
        out_err0 !== 1'b0 || in_ready0 !== 1'b1 || out_parity1 !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: valid=%0b sum=%02h count=%0d err=%0b ready=%0b required 0 00 0 0 1",
               out_valid0, out_sum0, out_count0, out_err0, in_ready0);
    end
    #1;
    rst = 1'b0;
    m_acc = '0;
    m_cnt = 0;
    sb.delete();
    drive_beat(8'h80, 1'b1);
    check_result("post_reset");
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_single_beat();
    test_overlength();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
